// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the keypad calculator sequencer.
package calc_pkg;

  localparam int DEFAULT_MAX_DIGITS  = 3;
  localparam int DEFAULT_ALU_TIMEOUT = 15;

  localparam logic [3:0] KEY_ADD       = 4'hA;
  localparam logic [3:0] KEY_SUB       = 4'hB;
  localparam logic [3:0] KEY_SIGN      = 4'hC;
  localparam logic [3:0] KEY_CLR_ENTRY = 4'hD;
  localparam logic [3:0] KEY_CLR_ALL   = 4'hE;
  localparam logic [3:0] KEY_EQ        = 4'hF;

  localparam logic [3:0] SIGN_POS = 4'h0;
  localparam logic [3:0] SIGN_NEG = 4'h1;

  localparam logic [7:0] ERR_VALUE = 8'h80;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_OP_WAIT = 3'd1,
    ST_ENTER_B = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4,
    ST_ERROR   = 3'd5
  } calc_state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Start/done handshake and operand bus between the sequencer and the external ALU.
interface calc_sequencer_if;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       alu_sub;
  logic       alu_start;
  logic       alu_done;
  logic [7:0] alu_result;
  logic       alu_ovf;

  modport master (
    output op_a, op_b, alu_sub, alu_start,
    input  alu_done, alu_result, alu_ovf
  );

  modport slave (
    input  op_a, op_b, alu_sub, alu_start,
    output alu_done, alu_result, alu_ovf
  );
endinterface

// File: rtl/calc_sequencer_bcd_entry.sv
// bcd_entry_reg: signed BCD operand being typed, with digit limit, sign toggle and clear.
module bcd_entry_reg
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = DEFAULT_MAX_DIGITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        shift_digit,
  input  logic        load_digit,
  input  logic        toggle_sign,
  input  logic        clear_entry,
  input  logic [3:0]  digit,
  output logic [15:0] bcd_out
);

  logic [1:0] count;

  // A load starts a fresh operand with one digit; leading zeros still use up a digit slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcd_out <= '0;
      count   <= '0;
    end else if (clear_entry) begin
      bcd_out <= '0;
      count   <= '0;
    end else if (load_digit) begin
      bcd_out <= {SIGN_POS, 8'h00, digit};
      count   <= 2'd1;
    end else if (shift_digit) begin
      if (count < 2'(MAX_DIGITS)) begin
        bcd_out[11:0] <= {bcd_out[7:0], digit};
        count         <= count + 2'd1;
      end
    end else if (toggle_sign) begin
      bcd_out[15:12] <= (bcd_out[15:12] == SIGN_NEG) ? SIGN_POS : SIGN_NEG;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator control FSM: operand entry, one ALU add/sub, result hold.
// Define CALC_CHAIN_EN to let A/B in SHOW chain the held result into a new operation.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS  = DEFAULT_MAX_DIGITS,
  parameter int ALU_TIMEOUT = DEFAULT_ALU_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [15:0]      bcd_out,
  input  logic [7:0]       bin_in,
  input  logic             bin_invalid,
  calc_sequencer_if.master alu,
  output logic [7:0]       result,
  output logic [2:0]       state_o,
  output logic             error
);

  localparam int TW = $clog2(ALU_TIMEOUT + 1);

  calc_state_t   state;
  logic [7:0]    result_q;
  logic [TW-1:0] timer;
  logic          key_digit;
  logic          key_op;
  logic          shift_digit;
  logic          load_digit;
  logic          toggle_sign;
  logic          clear_entry;

  assign key_digit = is_digit(key_code);
  assign key_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB);
  assign state_o   = state;

  always_comb begin
    shift_digit = 1'b0;
    load_digit  = 1'b0;
    toggle_sign = 1'b0;
    clear_entry = 1'b0;
    if (key_valid) begin
      if (key_code == KEY_CLR_ALL) begin
        clear_entry = 1'b1;
      end else begin
        case (state)
          ST_ENTER_A, ST_ENTER_B: begin
            if (key_digit)                           shift_digit = 1'b1;
            else if (key_code == KEY_SIGN)           toggle_sign = 1'b1;
            else if (key_code == KEY_CLR_ENTRY)      clear_entry = 1'b1;
            else if (state == ST_ENTER_A && key_op)  clear_entry = 1'b1;
          end
          ST_OP_WAIT: begin
            if (key_digit) load_digit = 1'b1;
          end
          ST_SHOW: begin
            if (key_digit) load_digit = 1'b1;
`ifdef CALC_CHAIN_EN
            else if (key_op) clear_entry = 1'b1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  bcd_entry_reg #(.MAX_DIGITS(MAX_DIGITS)) u_entry (
    .clock       (clock),
    .reset       (reset),
    .shift_digit (shift_digit),
    .load_digit  (load_digit),
    .toggle_sign (toggle_sign),
    .clear_entry (clear_entry),
    .digit       (key_code),
    .bcd_out     (bcd_out)
  );

  // E overrides everything, including an alu_done in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_ENTER_A;
      alu.op_a      <= '0;
      alu.op_b      <= '0;
      alu.alu_sub   <= 1'b0;
      alu.alu_start <= 1'b0;
      result_q      <= '0;
      error         <= 1'b0;
      timer         <= '0;
    end else begin
      alu.alu_start <= 1'b0;
      if (key_valid && key_code == KEY_CLR_ALL) begin
        state       <= ST_ENTER_A;
        alu.op_a    <= '0;
        alu.op_b    <= '0;
        alu.alu_sub <= 1'b0;
        result_q    <= '0;
        error       <= 1'b0;
        timer       <= '0;
      end else begin
        case (state)
          ST_ENTER_A: begin
            if (key_valid && key_op) begin
              if (bin_invalid) begin
                state <= ST_ERROR;
                error <= 1'b1;
              end else begin
                alu.op_a    <= bin_in;
                alu.alu_sub <= (key_code == KEY_SUB);
                state       <= ST_OP_WAIT;
              end
            end
          end
          ST_OP_WAIT: begin
            if (key_valid) begin
              if (key_digit)   state       <= ST_ENTER_B;
              else if (key_op) alu.alu_sub <= (key_code == KEY_SUB);
            end
          end
          ST_ENTER_B: begin
            if (key_valid && key_code == KEY_EQ) begin
              if (bin_invalid) begin
                state <= ST_ERROR;
                error <= 1'b1;
              end else begin
                alu.op_b      <= bin_in;
                alu.alu_start <= 1'b1;
                timer         <= '0;
                state         <= ST_EXEC;
              end
            end
          end
          // Timer counts the cycles since alu_start; the last allowed done cycle is ALU_TIMEOUT-1.
          ST_EXEC: begin
            if (alu.alu_done) begin
              result_q <= alu.alu_result;
              if (alu.alu_ovf) begin
                state <= ST_ERROR;
                error <= 1'b1;
              end else begin
                state <= ST_SHOW;
              end
            end else if (timer == TW'(ALU_TIMEOUT - 1)) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_SHOW: begin
            if (key_valid) begin
              if (key_digit) begin
                state <= ST_ENTER_A;
              end
`ifdef CALC_CHAIN_EN
              else if (key_op) begin
                alu.op_a    <= result_q;
                alu.alu_sub <= (key_code == KEY_SUB);
                state       <= ST_OP_WAIT;
              end
`endif
            end
          end
          ST_ERROR: ;
          default: begin
            state <= ST_ENTER_A;
            error <= 1'b0;
          end
        endcase
      end
    end
  end

  // While typing, the display follows the live conversion of the operand.
  always_comb begin
    case (state)
      ST_ENTER_A, ST_ENTER_B: result = bin_in;
      ST_ERROR:               result = ERR_VALUE;
      default:                result = result_q;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer; a behavioural BCD converter closes the loop.
module tb_calc_sequencer;

  logic        clock;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] bcd_out;
  logic [7:0]  bin_in;
  logic        bin_invalid;
  logic [7:0]  result;
  logic [2:0]  state_o;
  logic        error;
  int          checks;
  int          failures;
  int          start_pulses;
  int          pulses_before;

  calc_sequencer_if alu_bus ();

  calc_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .bcd_out     (bcd_out),
    .bin_in      (bin_in),
    .bin_invalid (bin_invalid),
    .alu         (alu_bus),
    .result      (result),
    .state_o     (state_o),
    .error       (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in for the combinational BCD -> two's-complement converter.
  always_comb begin
    int mag;
    int val;
    logic nonbcd;
    nonbcd = (bcd_out[11:8] > 4'd9) || (bcd_out[7:4] > 4'd9) || (bcd_out[3:0] > 4'd9);
    mag = int'(bcd_out[11:8]) * 100 + int'(bcd_out[7:4]) * 10 + int'(bcd_out[3:0]);
    val = bcd_out[12] ? -mag : mag;
    bin_in = val[7:0];
    bin_invalid = nonbcd || (bcd_out[12] ? (mag > 128) : (mag > 127));
  end

  always @(negedge clock) begin
    if (alu_bus.alu_start === 1'b1) start_pulses++;
  end

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] key);
    @(negedge clock);
    key_valid = 1'b1;
    key_code  = key;
    @(negedge clock);
    key_valid = 1'b0;
  endtask

  task automatic alu_respond(input int delay, input logic [7:0] res, input logic ovf,
                             input logic with_key, input logic [3:0] key);
    repeat (delay) @(negedge clock);
    alu_bus.alu_done   = 1'b1;
    alu_bus.alu_result = res;
    alu_bus.alu_ovf    = ovf;
    key_valid          = with_key;
    key_code           = key;
    @(negedge clock);
    alu_bus.alu_done = 1'b0;
    alu_bus.alu_ovf  = 1'b0;
    key_valid        = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    start_pulses = 0;
    reset = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    alu_bus.alu_done = 1'b0;
    alu_bus.alu_result = 8'h00;
    alu_bus.alu_ovf = 1'b0;

    repeat (2) @(negedge clock);
    check_output("rst_state", 16'(state_o), 16'd0);
    check_output("rst_bcd", bcd_out, 16'h0000);
    check_output("rst_op_a", 16'(alu_bus.op_a), 16'h0000);
    check_output("rst_op_b", 16'(alu_bus.op_b), 16'h0000);
    check_output("rst_result", 16'(result), 16'h0000);
    check_output("rst_ctrl", {13'd0, alu_bus.alu_sub, alu_bus.alu_start, error}, 16'h0000);
    reset = 1'b1;

    // 12 + 5 = 17
    apply_stimulus(4'h1);
    apply_stimulus(4'h2);
    check_output("t1_bcd_a", bcd_out, 16'h0012);
    check_output("t1_live_result", 16'(result), 16'd12);
    apply_stimulus(4'hA);
    check_output("t1_state_opwait", 16'(state_o), 16'd1);
    check_output("t1_op_a", 16'(alu_bus.op_a), 16'd12);
    check_output("t1_bcd_cleared", bcd_out, 16'h0000);
    apply_stimulus(4'h5);
    check_output("t1_state_enter_b", 16'(state_o), 16'd2);
    check_output("t1_bcd_b", bcd_out, 16'h0005);
    pulses_before = start_pulses;
    apply_stimulus(4'hF);
    check_output("t1_state_exec", 16'(state_o), 16'd3);
    check_output("t1_start", 16'(alu_bus.alu_start), 16'd1);
    check_output("t1_op_b", 16'(alu_bus.op_b), 16'd5);
    check_output("t1_sub", 16'(alu_bus.alu_sub), 16'd0);
    alu_respond(3, 8'd17, 1'b0, 1'b0, 4'h0);
    check_output("t1_pulses", 16'(start_pulses - pulses_before), 16'd1);
    check_output("t1_state_show", 16'(state_o), 16'd4);
    check_output("t1_result", 16'(result), 16'd17);

    // -9 - 30 = -39
    apply_stimulus(4'h9);
    check_output("t2_state_enter_a", 16'(state_o), 16'd0);
    check_output("t2_bcd_new", bcd_out, 16'h0009);
    apply_stimulus(4'hC);
    check_output("t2_bcd_neg", bcd_out, 16'h1009);
    check_output("t2_live_neg", 16'(result), 16'h00F7);
    apply_stimulus(4'hB);
    check_output("t2_op_a", 16'(alu_bus.op_a), 16'h00F7);
    check_output("t2_sub", 16'(alu_bus.alu_sub), 16'd1);
    apply_stimulus(4'h3);
    apply_stimulus(4'h0);
    apply_stimulus(4'hF);
    check_output("t2_op_b", 16'(alu_bus.op_b), 16'h001E);
    alu_respond(2, 8'hD9, 1'b0, 1'b0, 4'h0);
    check_output("t2_result", 16'(result), 16'h00D9);

    // 200 does not fit in 8 bits signed
    apply_stimulus(4'hE);
    apply_stimulus(4'h2);
    apply_stimulus(4'h0);
    apply_stimulus(4'h0);
    check_output("t3_invalid_in", 16'(bin_invalid), 16'd1);
    apply_stimulus(4'hA);
    check_output("t3_state_err", 16'(state_o), 16'd5);
    check_output("t3_error", 16'(error), 16'd1);
    check_output("t3_result_err", 16'(result), 16'h0080);
    apply_stimulus(4'h5);
    check_output("t3_err_sticky", 16'(state_o), 16'd5);
    apply_stimulus(4'hE);
    check_output("t3_clr_state", 16'(state_o), 16'd0);
    check_output("t3_clr_error", 16'(error), 16'd0);
    check_output("t3_clr_bcd", bcd_out, 16'h0000);
    check_output("t3_clr_result", 16'(result), 16'h0000);
    check_output("t3_clr_ops", {alu_bus.op_a, alu_bus.op_b}, 16'h0000);

    // digit limit, clear entry, leading zeros
    apply_stimulus(4'h1);
    apply_stimulus(4'h2);
    apply_stimulus(4'h3);
    apply_stimulus(4'h4);
    check_output("t4_digit_limit", bcd_out, 16'h0123);
    apply_stimulus(4'hD);
    check_output("t4_clear_entry", bcd_out, 16'h0000);
    apply_stimulus(4'h7);
    check_output("t4_after_clear", bcd_out, 16'h0007);
    apply_stimulus(4'hD);
    apply_stimulus(4'h0);
    apply_stimulus(4'h0);
    apply_stimulus(4'h0);
    apply_stimulus(4'h5);
    check_output("t4_leading_zeros", bcd_out, 16'h0000);
    apply_stimulus(4'hD);

    // timeout: ERROR exactly 15 cycles after alu_start
    apply_stimulus(4'h1);
    apply_stimulus(4'hA);
    apply_stimulus(4'h1);
    apply_stimulus(4'hF);
    check_output("t5_start", 16'(alu_bus.alu_start), 16'd1);
    repeat (14) @(negedge clock);
    check_output("t5_still_exec", 16'(state_o), 16'd3);
    @(negedge clock);
    check_output("t5_timeout_state", 16'(state_o), 16'd5);
    check_output("t5_timeout_result", 16'(result), 16'h0080);
    apply_stimulus(4'hE);

    // overflow flag forces ERROR
    apply_stimulus(4'h1);
    apply_stimulus(4'hA);
    apply_stimulus(4'h1);
    apply_stimulus(4'hF);
    alu_respond(1, 8'h7F, 1'b1, 1'b0, 4'h0);
    check_output("t5_ovf_state", 16'(state_o), 16'd5);
    check_output("t5_ovf_error", 16'(error), 16'd1);
    apply_stimulus(4'hE);

    // key arriving with alu_done in EXEC is dropped
    apply_stimulus(4'h4);
    apply_stimulus(4'hA);
    apply_stimulus(4'h4);
    apply_stimulus(4'hF);
    alu_respond(1, 8'd8, 1'b0, 1'b1, 4'h7);
    check_output("t5_done_key_state", 16'(state_o), 16'd4);
    check_output("t5_done_key_bcd", bcd_out, 16'h0004);
    check_output("t5_done_key_result", 16'(result), 16'd8);
    apply_stimulus(4'hE);

    // SHOW with result 17, then A,3,F
    apply_stimulus(4'h1);
    apply_stimulus(4'h2);
    apply_stimulus(4'hA);
    apply_stimulus(4'h5);
    apply_stimulus(4'hF);
    alu_respond(1, 8'd17, 1'b0, 1'b0, 4'h0);
    apply_stimulus(4'hA);
`ifdef CALC_CHAIN_EN
    check_output("t6_chain_state", 16'(state_o), 16'd1);
    check_output("t6_chain_op_a", 16'(alu_bus.op_a), 16'd17);
    apply_stimulus(4'h3);
    apply_stimulus(4'hF);
    check_output("t6_chain_exec", 16'(state_o), 16'd3);
    check_output("t6_chain_op_b", 16'(alu_bus.op_b), 16'd3);
    alu_respond(1, 8'd20, 1'b0, 1'b0, 4'h0);
    check_output("t6_chain_result", 16'(result), 16'd20);
`else
    check_output("t6_show_hold", 16'(state_o), 16'd4);
    check_output("t6_show_result", 16'(result), 16'd17);
    apply_stimulus(4'h3);
    apply_stimulus(4'hF);
    check_output("t6_new_entry_state", 16'(state_o), 16'd0);
    check_output("t6_new_entry_bcd", bcd_out, 16'h0003);
`endif
    apply_stimulus(4'hE);

    // async reset mid-EXEC, late alu_done ignored
    apply_stimulus(4'h1);
    apply_stimulus(4'hA);
    apply_stimulus(4'h2);
    apply_stimulus(4'hF);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_output("t6_rst_state", 16'(state_o), 16'd0);
    check_output("t6_rst_op_a", 16'(alu_bus.op_a), 16'h0000);
    check_output("t6_rst_bcd", bcd_out, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    alu_respond(0, 8'h55, 1'b0, 1'b0, 4'h0);
    check_output("t6_late_done_state", 16'(state_o), 16'd0);
    check_output("t6_late_done_result", 16'(result), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
